tap_controller: RTL and testbench

IEEE 1149.1 TAP controller that sequences the instruction-register and data-register cells of the JTAG block. It holds the 16-state TAP state machine, clocked by TCK and steered by TMS. It produces the shift, clock and update controls consumed by the IR cells (ShiftIR, ClockIR, UpdateIR) and by the DR cells (ShiftDR, ClockDR, UpdateDR). It also produces the TDO-enable, IR/DR select and the active-high test-logic reset that clears the IR cells.

---
 rtl/tap_controller.sv | 141 ++++++++++++++
 tb/tb_tap_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on rising TCK, control flops on falling TCK, gated IR/DR clocks.
// Defining TAP_STATE_DBG_EN adds the TapState[3:0] debug output carrying the state register.
module tap_controller (
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic       TapReset,
    output logic       ShiftIR,
    output logic       ClockIR,
    output logic       UpdateIR,
    output logic       ShiftDR,
    output logic       ClockDR,
    output logic       UpdateDR,
    output logic       Select,
    output logic       Enable
`ifdef TAP_STATE_DBG_EN
    ,
    output logic [3:0] TapState
`endif
);
    localparam logic [3:0] TLR   = 4'hF, RTI     = 4'hC, SELDR = 4'h7, CAPDR = 4'h6;
    localparam logic [3:0] SHDR  = 4'h2, EX1DR   = 4'h1, PAUSEDR = 4'h3, EX2DR = 4'h0;
    localparam logic [3:0] UPDDR = 4'h5, SELIR   = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA;
    localparam logic [3:0] EX1IR = 4'h9, PAUSEIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD;

    logic [3:0] state_q, state_d;
    logic tap_reset_q, shift_ir_q, shift_dr_q, enable_q, select_q;
    logic update_ir_q, update_dr_q, clk_en_ir_q, clk_en_dr_q;
    logic tap_reset_d, shift_ir_d, shift_dr_d, enable_d, select_d;
    logic update_ir_d, update_dr_d, clk_en_ir_d, clk_en_dr_d;

    // State register, advanced on rising TCK
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic steered by TMS
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = TMS ? TLR   : RTI;
            RTI:     state_d = TMS ? SELDR : RTI;
            SELDR:   state_d = TMS ? SELIR : CAPDR;
            SELIR:   state_d = TMS ? TLR   : CAPIR;
            CAPDR:   state_d = TMS ? EX1DR : SHDR;
            SHDR:    state_d = TMS ? EX1DR : SHDR;
            EX1DR:   state_d = TMS ? UPDDR : PAUSEDR;
            PAUSEDR: state_d = TMS ? EX2DR : PAUSEDR;
            EX2DR:   state_d = TMS ? UPDDR : SHDR;
            UPDDR:   state_d = TMS ? SELDR : RTI;
            CAPIR:   state_d = TMS ? EX1IR : SHIR;
            SHIR:    state_d = TMS ? EX1IR : SHIR;
            EX1IR:   state_d = TMS ? UPDIR : PAUSEIR;
            PAUSEIR: state_d = TMS ? EX2IR : PAUSEIR;
            EX2IR:   state_d = TMS ? UPDIR : SHIR;
            UPDIR:   state_d = TMS ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Control decode of the current state, registered on the following falling TCK
    always_comb begin
        tap_reset_d = 1'b0;
        shift_ir_d  = 1'b0;
        shift_dr_d  = 1'b0;
        enable_d    = 1'b0;
        select_d    = 1'b0;
        update_ir_d = 1'b0;
        update_dr_d = 1'b0;
        clk_en_ir_d = 1'b0;
        clk_en_dr_d = 1'b0;
        case (state_q)
            TLR:   tap_reset_d = 1'b1;
            CAPIR: begin
                select_d    = 1'b1;
                clk_en_ir_d = 1'b1;
            end
            SHIR: begin
                select_d    = 1'b1;
                shift_ir_d  = 1'b1;
                enable_d    = 1'b1;
                clk_en_ir_d = 1'b1;
            end
            EX1IR, PAUSEIR, EX2IR: select_d = 1'b1;
            UPDIR: begin
                select_d    = 1'b1;
                update_ir_d = 1'b1;
            end
            CAPDR: clk_en_dr_d = 1'b1;
            SHDR: begin
                shift_dr_d  = 1'b1;
                enable_d    = 1'b1;
                clk_en_dr_d = 1'b1;
            end
            UPDDR: update_dr_d = 1'b1;
            default: tap_reset_d = 1'b0;
        endcase
    end

    // Falling-edge control flops; clock enables only move while TCK is low
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tap_reset_q <= 1'b1;
            shift_ir_q  <= 1'b0;
            shift_dr_q  <= 1'b0;
            enable_q    <= 1'b0;
            select_q    <= 1'b0;
            update_ir_q <= 1'b0;
            update_dr_q <= 1'b0;
            clk_en_ir_q <= 1'b0;
            clk_en_dr_q <= 1'b0;
        end else begin
            tap_reset_q <= tap_reset_d;
            shift_ir_q  <= shift_ir_d;
            shift_dr_q  <= shift_dr_d;
            enable_q    <= enable_d;
            select_q    <= select_d;
            update_ir_q <= update_ir_d;
            update_dr_q <= update_dr_d;
            clk_en_ir_q <= clk_en_ir_d;
            clk_en_dr_q <= clk_en_dr_d;
        end
    end

    assign TapReset = tap_reset_q;
    assign ShiftIR  = shift_ir_q;
    assign ShiftDR  = shift_dr_q;
    assign Enable   = enable_q;
    assign Select   = select_q;
    assign UpdateIR = update_ir_q;
    assign UpdateDR = update_dr_q;
    assign ClockIR  = TCK & clk_en_ir_q;
    assign ClockDR  = TCK & clk_en_dr_q;
`ifdef TAP_STATE_DBG_EN
    assign TapState = state_q;
`endif
endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: a table-driven TAP model queues the expected state per TCK,
// a monitor compares outputs on falling TCK and gated clocks on rising TCK.
module tb_tap_controller;
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6;
    localparam logic [3:0] S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0;
    localparam logic [3:0] S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA;
    localparam logic [3:0] S_EX1IR = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD;

    logic TCK = 1'b0;
    logic TRST = 1'b1;
    logic TMS = 1'b1;
    logic TapReset, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, Select, Enable;
    logic [3:0] act_state;

    int n_tests = 0;
    int n_fail = 0;
    int cnt_clkir = 0, cnt_shedge = 0, cnt_clkdr = 0, cnt_updir = 0, cnt_upddr = 0, cnt_sel = 0;

    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic [3:0] m_state = S_TLR;
    logic [3:0] last_exp = S_TLR;
    logic [3:0] sb_q [$];

`ifdef TAP_STATE_DBG_EN
    logic [3:0] tap_state;
    assign act_state = tap_state;
`else
    assign act_state = dut.state_q;
`endif

    tap_controller dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS),
        .TapReset(TapReset), .ShiftIR(ShiftIR), .ClockIR(ClockIR), .UpdateIR(UpdateIR),
        .ShiftDR(ShiftDR), .ClockDR(ClockDR), .UpdateDR(UpdateDR),
        .Select(Select), .Enable(Enable)
`ifdef TAP_STATE_DBG_EN
        , .TapState(tap_state)
`endif
    );

    initial forever #5 TCK = ~TCK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    always @(posedge ClockIR) begin
        cnt_clkir++;
        if (ShiftIR) cnt_shedge++;
    end
    always @(posedge ClockDR)  cnt_clkdr++;
    always @(posedge UpdateIR) cnt_updir++;
    always @(posedge UpdateDR) cnt_upddr++;
    always @(posedge Select)   cnt_sel++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {TapReset,ShiftIR,ShiftDR,Enable,Select,UpdateIR,UpdateDR,ClkEnIR,ClkEnDR}
    function automatic logic [8:0] exp_out(input logic [3:0] s);
        exp_out = {s == S_TLR, s == S_SHIR, s == S_SHDR, (s == S_SHIR) || (s == S_SHDR),
                   s inside {S_CAPIR, S_SHIR, S_EX1IR, S_PAUSEIR, S_EX2IR, S_UPDIR},
                   s == S_UPDIR, s == S_UPDDR,
                   s inside {S_CAPIR, S_SHIR}, s inside {S_CAPDR, S_SHDR}};
    endfunction

    task automatic arc(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    task automatic init_model();
        arc(S_TLR, S_RTI, S_TLR);         arc(S_RTI, S_RTI, S_SELDR);
        arc(S_SELDR, S_CAPDR, S_SELIR);   arc(S_SELIR, S_CAPIR, S_TLR);
        arc(S_CAPDR, S_SHDR, S_EX1DR);    arc(S_SHDR, S_SHDR, S_EX1DR);
        arc(S_EX1DR, S_PAUSEDR, S_UPDDR); arc(S_PAUSEDR, S_PAUSEDR, S_EX2DR);
        arc(S_EX2DR, S_SHDR, S_UPDDR);    arc(S_UPDDR, S_RTI, S_SELDR);
        arc(S_CAPIR, S_SHIR, S_EX1IR);    arc(S_SHIR, S_SHIR, S_EX1IR);
        arc(S_EX1IR, S_PAUSEIR, S_UPDIR); arc(S_PAUSEIR, S_PAUSEIR, S_EX2IR);
        arc(S_EX2IR, S_SHIR, S_UPDIR);    arc(S_UPDIR, S_RTI, S_SELDR);
    endtask

    // Called at falling TCK + 2; returns at the next such slot with the new state's outputs visible
    task automatic step(input logic tms);
        TMS = tms;
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
        sb_q.push_back(m_state);
        @(negedge TCK); #2;
    endtask

    task automatic ir_scan(input int n);
        int b_clk = cnt_clkir, b_sh = cnt_shedge, b_upd = cnt_updir, b_dr = cnt_clkdr;
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        for (int i = 0; i < n - 1; i++) step(1'b0);
        step(1'b1); step(1'b1); step(1'b0);
        check("ir_clock_edges", 32'(cnt_clkir - b_clk), 32'(n + 1));
        check("ir_shift_edges", 32'(cnt_shedge - b_sh), 32'(n));
        check("ir_update_pulses", 32'(cnt_updir - b_upd), 32'd1);
        check("ir_no_clockdr", 32'(cnt_clkdr - b_dr), 32'd0);
        check("ir_end_rti", 32'(act_state), 32'(S_RTI));
    endtask

    // Rising-TCK monitor for the gated clocks
    initial begin : mon_high
        logic [8:0] o;
        forever begin
            @(posedge TCK); #1;
            o = exp_out(last_exp);
            check("gated_clk_high", 32'({ClockIR, ClockDR}), TRST ? 32'(o[1:0]) : 32'd0);
        end
    end

    // Falling-TCK monitor popping the scoreboard
    initial begin : mon_low
        logic [3:0] e;
        logic [8:0] o;
        forever begin
            @(negedge TCK); #1;
            if (!TRST) begin
                last_exp = S_TLR;
            end else if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                o = exp_out(e);
                check("state", 32'(act_state), 32'(e));
                check("outputs", 32'({TapReset, ShiftIR, ShiftDR, Enable, Select, UpdateIR, UpdateDR}),
                      32'(o[8:2]));
                check("gated_clk_low", 32'({ClockIR, ClockDR}), 32'd0);
                last_exp = e;
            end
        end
    end

    initial begin : driver
        int guard, b_ir, b_dr, b_upd, b_ud, b_sel;
        logic [3:0] target;
        init_model();

        // Asynchronous reset with no clock edge
        #1 TRST = 1'b0;
        #2;
        check("rst_tapreset", 32'(TapReset), 32'd1);
        check("rst_outs", 32'({ShiftIR, ShiftDR, UpdateIR, UpdateDR, Enable, Select, ClockIR, ClockDR}), 32'd0);
        check("rst_state", 32'(act_state), 32'(S_TLR));
        @(negedge TCK); #2;
        TRST = 1'b1;
        @(negedge TCK); #2;
        check("tlr_hold", 32'(act_state), 32'(S_TLR));
        step(1'b0);
        check("first_fall_tapreset", 32'(TapReset), 32'd0);
        step(1'b0); step(1'b0);
        check("idle_rti", 32'(act_state), 32'(S_RTI));

        ir_scan(4);
        ir_scan($urandom_range(1, 8));

        // DR scan with a pause
        b_ir = cnt_clkir; b_dr = cnt_clkdr; b_ud = cnt_upddr; b_sel = cnt_sel;
        step(1'b1); step(1'b0); step(1'b0); step(1'b0); step(1'b1);
        step(1'b0); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
        check("dr_no_clockir", 32'(cnt_clkir - b_ir), 32'd0);
        check("dr_clock_edges", 32'(cnt_clkdr - b_dr), 32'd3);
        check("dr_update_pulses", 32'(cnt_upddr - b_ud), 32'd1);
        check("dr_select_low", 32'(cnt_sel - b_sel), 32'd0);
        check("dr_end_rti", 32'(act_state), 32'(S_RTI));

        // TRST in the middle of an IR shift
        step(1'b1); step(1'b1); step(1'b0); step(1'b0); step(1'b0);
        b_upd = cnt_updir;
        TMS = 1'b0;
        @(posedge TCK); #2;
        check("midshift_clockir_on", 32'(ClockIR), 32'd1);
        sb_q.delete();
        TRST = 1'b0;
        #1;
        check("midshift_drop", 32'({ShiftIR, Enable, ClockIR}), 32'd0);
        check("midshift_tapreset", 32'(TapReset), 32'd1);
        check("midshift_state", 32'(act_state), 32'(S_TLR));
        TMS = 1'b1;
        m_state = S_TLR;
        @(negedge TCK); #2;
        TRST = 1'b1;
        @(negedge TCK); #2;
        step(1'b0); step(1'b0);
        check("midshift_no_update", 32'(cnt_updir - b_upd), 32'd0);

        // Reach every state, then five TMS=1 must land in TLR
        for (int t = 0; t < 16; t++) begin
            target = 4'(t);
            guard = 0;
            while (m_state != target && guard < 400) begin
                step(1'($urandom_range(0, 1)));
                guard++;
            end
            check("reach_state", 32'(act_state), 32'(target));
            for (int k = 0; k < 5; k++) step(1'b1);
            check("five_tms_tlr", 32'(act_state), 32'(S_TLR));
            check("five_tms_tapreset", 32'(TapReset), 32'd1);
        end

        // Random TMS traffic checked cycle by cycle by the scoreboard
        for (int i = 0; i < 400; i++) step(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
